// File: rtl/set_cmd_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : set_cmd_dispatcher_if
// Description : Bundle of host-command, SET-engine and host-result signals
//               for set_cmd_dispatcher.
//               master = environment side (host + SET engine)
//               slave  = dispatcher side
//   cmd_*      host command channel (valid/ready)
//   set_*      SET engine start pulse, operands, and returned result
//   res_*      result channel back to host (valid/ready)
//   fifo_count entries held in the command FIFO
//   idle       dispatcher idle with an empty FIFO
// Revision    : 1.0 - initial release
// ============================================================================
interface set_cmd_dispatcher_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_central;
  logic [11:0]      cmd_radius;
  logic [1:0]       cmd_mode;

  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_valid;
  logic [7:0]       set_candidate;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;

  logic [CNT_W-1:0] fifo_count;
  logic             idle;

  modport master (
    output cmd_valid, cmd_central, cmd_radius, cmd_mode,
    output set_valid, set_candidate,
    output res_ready,
    input  cmd_ready,
    input  set_en, set_central, set_radius, set_mode,
    input  res_valid, res_candidate, res_tag, res_timeout,
    input  fifo_count, idle
  );

  modport slave (
    input  cmd_valid, cmd_central, cmd_radius, cmd_mode,
    input  set_valid, set_candidate,
    input  res_ready,
    output cmd_ready,
    output set_en, set_central, set_radius, set_mode,
    output res_valid, res_candidate, res_tag, res_timeout,
    output fifo_count, idle
  );
endinterface
`default_nettype wire

// File: rtl/set_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : set_cmd_dispatcher
// Description : Buffers host commands in a FIFO and issues them one at a time
//               to the SET circle-candidate engine. Each command gives one
//               set_en pulse; the operands are held while waiting for SET
//               valid, and the candidate count plus a sequence tag is returned
//               to the host. A watchdog turns a silent SET into a timeout
//               result.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - set_cmd_dispatcher_if.slave (cmd_*, set_*, res_*,
//                      fifo_count, idle)
// Revision    : 1.0 - initial release
// ============================================================================
module set_cmd_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  set_cmd_dispatcher_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int WD_W  = 9;
  localparam logic [WD_W-1:0]  C_TIMEOUT = WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } cmd_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  cmd_t              op_q;
  logic [7:0]        cand_q, cand_d;
  logic              timeout_q, timeout_d;
  logic [TAG_W-1:0]  tag_q;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              res_hs;

  assign full   = (count_q == C_DEPTH);
  assign empty  = (count_q == '0);
  // Push looks only at the current fullness: a same-cycle pop does not
  // free a slot for a push.
  assign push   = bus.cmd_valid && !full;
  assign res_hs = (state_q == ST_RESP) && bus.res_ready;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{central: bus.cmd_central,
                           radius:  bus.cmd_radius,
                           mode:    bus.cmd_mode};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and result capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    cand_d    = cand_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A real answer takes priority over a watchdog expiry in the same cycle.
        if (bus.set_valid) begin
          cand_d    = bus.set_candidate;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (wd_q == C_TIMEOUT) begin
          cand_d    = 8'd0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      cand_q    <= '0;
      timeout_q <= 1'b0;
      tag_q     <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      cand_q    <= cand_d;
      timeout_q <= timeout_d;
      if (res_hs) tag_q <= tag_q + TAG_W'(1);
      // Operands change only on a pop so SET sees them stable for the whole
      // transaction and they keep their last value afterwards.
      if (pop) op_q <= mem_q[rd_ptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cmd_ready     = !full;
  assign bus.set_en        = (state_q == ST_ISSUE);
  assign bus.set_central   = op_q.central;
  assign bus.set_radius    = op_q.radius;
  assign bus.set_mode      = op_q.mode;
  assign bus.res_valid     = (state_q == ST_RESP);
  assign bus.res_candidate = cand_q;
  assign bus.res_tag       = tag_q;
  assign bus.res_timeout   = timeout_q;
  assign bus.fifo_count    = count_q;
  assign bus.idle          = (state_q == ST_IDLE) && empty;

endmodule
`default_nettype wire

// File: tb/tb_set_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_cmd_dispatcher
// Description : Randomised self-checking bench for set_cmd_dispatcher. A SET
//               engine model answers issued commands after a random delay (or
//               never); a transaction-level model tracks queued commands,
//               expected results and tags, and a monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_cmd_dispatcher;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
  } cmd_s;

  typedef struct {
    logic [7:0] cand;
    logic       to;
    int         lat;
  } res_s;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_cmd_dispatcher_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  set_cmd_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // model state
  cmd_s pend_q[$];
  res_s exp_q[$];
  int   tag_log[$];
  int   n_pushed = 0, n_popped = 0, n_done = 0;
  int   cyc = 0, en_cyc = 0, push_cyc = 0;
  bit   in_txn = 0, have_snap = 0, prev_rv = 0, mon_en = 0;
  cmd_s snap;
  logic [12:0] rsnap;
  logic [7:0]  last_cand;
  logic        last_to;
  int          last_tag;

  // stimulus controls
  int set_mode  = 0;   // 0 answer, 1 silent then late pulse, 2 silent
  int min_delay = 0;
  int max_delay = 5;
  bit rand_silent = 0;
  bit hold = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference SET engine: count grid points (1..8 x 1..8) inside circles.
  function automatic bit in_c(int x, int y, logic [3:0] cx, logic [3:0] cy, logic [3:0] r);
    int dx, dy;
    dx = x - int'(cx);
    dy = y - int'(cy);
    return (dx * dx + dy * dy) <= int'(r) * int'(r);
  endfunction

  function automatic logic [7:0] set_ref(cmd_s k);
    int  n;
    bit  a, b, c;
    n = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        a = in_c(x, y, k.c[23:20], k.c[19:16], k.r[11:8]);
        b = in_c(x, y, k.c[15:12], k.c[11:8],  k.r[7:4]);
        c = in_c(x, y, k.c[7:4],   k.c[3:0],   k.r[3:0]);
        case (k.m)
          2'd0:    n += int'(a);
          2'd1:    n += int'(a && b);
          2'd2:    n += int'(a && b && c);
          default: n += int'(a && !b);
        endcase
      end
    end
    return 8'(n);
  endfunction

  function automatic cmd_s rand_cmd();
    cmd_s k;
    k.c = 24'($urandom);
    k.r = 12'($urandom);
    k.m = 2'($urandom_range(0, 3));
    return k;
  endfunction

  // ---------------- host command driver ----------------
  task automatic push_cmd(cmd_s k);
    int n;
    bit done;
    bus.cmd_central = k.c;
    bus.cmd_radius  = k.r;
    bus.cmd_mode    = k.m;
    bus.cmd_valid   = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 2000) begin
      if (bus.cmd_ready) begin
        @(posedge clk);
        pend_q.push_back(k);
        n_pushed++;
        push_cyc = cyc + 1;
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!done) check("push_accept_timeout", 64'(done), 64'(1));
  endtask

  task automatic wait_done(int target, int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_done_bound", 64'(n_done >= target), 64'(1));
  endtask

  task automatic wait_res_valid(int budget);
    int k;
    k = 0;
    while (!bus.res_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_res_valid_bound", 64'(bus.res_valid), 64'(1));
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    tag_log.delete();
    in_txn = 0;
    have_snap = 0;
    prev_rv = 0;
    n_done = 0;
  endtask

  // ---------------- result-ready driver ----------------
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.res_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- SET engine model ----------------
  initial begin : set_model
    int d;
    logic [7:0] cv;
    cmd_s k;
    bus.set_valid = 1'b0;
    bus.set_candidate = 8'd0;
    forever begin
      @(negedge clk);
      bus.set_candidate = 8'($urandom);
      if (bus.set_en && rst === 1'b1) begin
        k = '{c: bus.set_central, r: bus.set_radius, m: bus.set_mode};
        if (set_mode == 0 && !(rand_silent && $urandom_range(0, 11) == 0)) begin
          d  = $urandom_range(min_delay, max_delay);
          cv = set_ref(k);
          exp_q.push_back('{cand: cv, to: 1'b0, lat: d + 2});
          repeat (d + 1) @(negedge clk);
          bus.set_valid = 1'b1;
          bus.set_candidate = cv;
          @(negedge clk);
          bus.set_valid = 1'b0;
        end else begin
          exp_q.push_back('{cand: 8'd0, to: 1'b1, lat: TIMEOUT + 2});
          if (set_mode == 1) begin
            repeat (TIMEOUT + 6) @(negedge clk);
            bus.set_valid = 1'b1;
            bus.set_candidate = 8'hAA;
            @(negedge clk);
            bus.set_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : monitor
    cmd_s k;
    res_s e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        if (prev_rv && bus.res_ready) begin
          n_done++;
          in_txn = 0;
          check("res_valid_drop", 64'(bus.res_valid), 64'(0));
        end
        if (bus.set_en) begin
          check("set_en_while_busy", 64'(in_txn), 64'(0));
          check("issue_has_command", 64'(pend_q.size() > 0), 64'(1));
          if (pend_q.size() > 0) begin
            k = pend_q.pop_front();
            check("issue_operands", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'(k));
            snap = k;
          end
          n_popped++;
          in_txn = 1;
          have_snap = 1;
          en_cyc = cyc;
        end else if (have_snap) begin
          check("operand_hold", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'(snap));
        end
        check("fifo_count", 64'(bus.fifo_count), 64'(pend_q.size()));
        check("cmd_ready", 64'(bus.cmd_ready), 64'(pend_q.size() < DEPTH));
        check("idle", 64'(bus.idle), 64'(!in_txn && pend_q.size() == 0));
        if (bus.res_valid && !prev_rv) begin
          check("res_in_txn", 64'(in_txn), 64'(1));
          check("res_has_expectation", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("res_candidate", 64'(bus.res_candidate), 64'(e.cand));
            check("res_timeout", 64'(bus.res_timeout), 64'(e.to));
            check("res_latency", 64'(cyc - en_cyc), 64'(e.lat));
          end
          check("res_tag", 64'(bus.res_tag), 64'(n_done % (1 << TAG_W)));
          rsnap     = {bus.res_candidate, bus.res_tag, bus.res_timeout};
          last_cand = bus.res_candidate;
          last_to   = bus.res_timeout;
          last_tag  = int'(bus.res_tag);
          tag_log.push_back(int'(bus.res_tag));
        end else if (bus.res_valid) begin
          check("res_hold", 64'({bus.res_candidate, bus.res_tag, bus.res_timeout}), 64'(rsnap));
        end else if (!in_txn) begin
          check("no_result_outside_txn", 64'(bus.res_valid), 64'(0));
        end
        prev_rv = bus.res_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base, pops0;
    cmd_s k;
    bus.cmd_valid = 1'b0;
    bus.cmd_central = '0;
    bus.cmd_radius = '0;
    bus.cmd_mode = '0;

    // Power-on reset values
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_valid",  64'(bus.res_valid),  64'(0));
    check("rst_set_en",     64'(bus.set_en),     64'(0));
    check("rst_cmd_ready",  64'(bus.cmd_ready),  64'(1));
    check("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    check("rst_idle",       64'(bus.idle),       64'(1));
    check("rst_operands",   64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'(0));
    check("rst_result",     64'({bus.res_candidate, bus.res_tag, bus.res_timeout}), 64'(0));
    rst = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // Reset in the middle of WAIT with one more command queued
    set_mode = 2;
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'(bus.idle), 64'(0));
    @(posedge clk);
    #3;
    mon_en = 0;
    rst = 1'b0;
    #1;
    check("async_rst_res_valid",  64'(bus.res_valid),  64'(0));
    check("async_rst_set_en",     64'(bus.set_en),     64'(0));
    check("async_rst_cmd_ready",  64'(bus.cmd_ready),  64'(1));
    check("async_rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    check("async_rst_idle",       64'(bus.idle),       64'(1));
    clear_model();
    set_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1;
    repeat (3) @(negedge clk);

    // Single known command: circle r=3 at (4,4) covers 29 grid points
    pops0 = n_popped;
    k = '{c: 24'h440000, r: 12'h300, m: 2'd0};
    push_cmd(k);
    wait_done(1, 100);
    check("single_candidate", 64'(last_cand), 64'(29));
    check("single_tag",       64'(last_tag),  64'(0));
    check("single_timeout",   64'(last_to),   64'(0));
    check("single_en_count",  64'(n_popped - pops0), 64'(1));
    check("issue_latency",    64'(en_cyc - push_cyc), 64'(1));

    // Five back-to-back commands while SET is slow: FIFO fills
    min_delay = 30;
    max_delay = 30;
    base = n_done;
    pops0 = n_popped;
    for (int i = 0; i < 5; i++) push_cmd(rand_cmd());
    check("full_cmd_ready",  64'(bus.cmd_ready),  64'(0));
    check("full_fifo_count", 64'(bus.fifo_count), 64'(DEPTH));
    wait_done(base + 5, 1000);
    check("burst_en_count", 64'(n_popped - pops0), 64'(5));
    min_delay = 0;
    max_delay = 5;

    // Silent SET: watchdog result, then a late answer that must be ignored
    set_mode = 1;
    hold = 1;
    base = n_done;
    push_cmd(rand_cmd());
    wait_res_valid(TIMEOUT + 50);
    repeat (10) @(negedge clk);
    check("to_res_valid",  64'(bus.res_valid),     64'(1));
    check("to_flag",       64'(bus.res_timeout),   64'(1));
    check("to_candidate",  64'(bus.res_candidate), 64'(0));
    set_mode = 0;
    hold = 0;
    wait_done(base + 1, 50);

    // Host stalls the result for 20 cycles with another command queued
    hold = 1;
    base = n_done;
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    wait_res_valid(50);
    pops0 = n_popped;
    repeat (20) @(negedge clk);
    check("stall_fifo_count", 64'(bus.fifo_count), 64'(1));
    check("stall_no_issue",   64'(n_popped - pops0), 64'(0));
    hold = 0;
    wait_done(base + 2, 100);

    // Randomised traffic, occasional silent SET
    rand_silent = 1;
    base = n_done;
    for (int i = 0; i < 30; i++) begin
      push_cmd(rand_cmd());
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_done(base + 30, 20000);
    rand_silent = 0;
    repeat (5) @(negedge clk);

    // Clean restart, then 17 commands: tag wraps to 0 on the 17th
    mon_en = 0;
    rst = 1'b0;
    @(negedge clk);
    clear_model();
    rst = 1'b1;
    mon_en = 1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) push_cmd(rand_cmd());
    wait_done(17, 2000);
    check("wrap_log_size", 64'(tag_log.size()), 64'(17));
    if (tag_log.size() == 17) begin
      check("tag_16th", 64'(tag_log[15]), 64'(15));
      check("tag_17th", 64'(tag_log[16]), 64'(0));
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
